// File: rtl/uart_top_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_top_if
//  Description : Parallel and serial signal bundle for the 8N1 UART.
//                slave  modport - the UART itself
//                master modport - fabric / test driver side
//  Signals     : data_in[7:0], Tx_en, Rx, Rx_en, ready_clr  (toward UART)
//                Tx, Tx_busy, ready, data_out[7:0]           (from UART)
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_top_if;
    logic [7:0] data_in;
    logic       Tx_en;
    logic       Tx;
    logic       Tx_busy;
    logic       Rx;
    logic       Rx_en;
    logic       ready;
    logic       ready_clr;
    logic [7:0] data_out;

    modport slave (
        input  data_in, Tx_en, Rx, Rx_en, ready_clr,
        output Tx, Tx_busy, ready, data_out
    );

    modport master (
        output data_in, Tx_en, Rx, Rx_en, ready_clr,
        input  Tx, Tx_busy, ready, data_out
    );
endinterface
`default_nettype wire

// File: rtl/uart_top.sv
`default_nettype none
// ============================================================================
//  Module      : uart_top
//  Description : 8N1 UART - transmitter with a TX_DIV bit timer and a
//                16x-oversampling receiver with a RX_DIV tick timer.
//  Ports       : clk_50m - system clock (rising edge)
//                rst     - asynchronous active-high reset
//                bus     - uart_top_if.slave (byte handshake + serial pins)
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_top #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input  wire logic  clk_50m,
    input  wire logic  rst,
    uart_top_if.slave  bus
);
    localparam int c_TX_DIV = CLK_FREQ / BAUD;
    localparam int c_RX_DIV = CLK_FREQ / (16 * BAUD);
    localparam int c_TXW    = (c_TX_DIV > 1) ? $clog2(c_TX_DIV) : 1;
    localparam int c_RXW    = (c_RX_DIV > 1) ? $clog2(c_RX_DIV) : 1;
    localparam logic [c_TXW-1:0] c_TX_LAST = c_TXW'(c_TX_DIV - 1);
    localparam logic [c_RXW-1:0] c_RX_LAST = c_RXW'(c_RX_DIV - 1);

    typedef enum logic [1:0] {TX_IDLE = 2'd0, TX_START = 2'd1, TX_DATA = 2'd2, TX_STOP = 2'd3} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE = 2'd0, RX_START = 2'd1, RX_DATA = 2'd2, RX_STOP = 2'd3} rx_state_t;

    // ---------------- transmitter ----------------
    tx_state_t        r_tx_state_q, w_tx_state_d;
    logic [c_TXW-1:0] r_tx_div_q,   w_tx_div_d;
    logic [2:0]       r_tx_bit_q,   w_tx_bit_d;
    logic [7:0]       r_tx_shift_q, w_tx_shift_d;
    logic             w_tx_bit_end;

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            r_tx_state_q <= TX_IDLE;
            r_tx_div_q   <= '0;
            r_tx_bit_q   <= '0;
            r_tx_shift_q <= '0;
        end else begin
            r_tx_state_q <= w_tx_state_d;
            r_tx_div_q   <= w_tx_div_d;
            r_tx_bit_q   <= w_tx_bit_d;
            r_tx_shift_q <= w_tx_shift_d;
        end
    end

    always_comb begin
        w_tx_state_d = r_tx_state_q;
        w_tx_div_d   = r_tx_div_q;
        w_tx_bit_d   = r_tx_bit_q;
        w_tx_shift_d = r_tx_shift_q;
        w_tx_bit_end = (r_tx_div_q == c_TX_LAST);
        if (r_tx_state_q == TX_IDLE) begin
            // Divider held at zero so the start bit gets a full TX_DIV clocks.
            w_tx_div_d = '0;
            if (bus.Tx_en) begin
                w_tx_shift_d = bus.data_in;
                w_tx_bit_d   = '0;
                w_tx_state_d = TX_START;
            end
        end else begin
            w_tx_div_d = w_tx_bit_end ? '0 : r_tx_div_q + 1'b1;
            if (w_tx_bit_end) begin
                case (r_tx_state_q)
                    TX_START: w_tx_state_d = TX_DATA;
                    TX_DATA: begin
                        w_tx_shift_d = {1'b0, r_tx_shift_q[7:1]};
                        w_tx_bit_d   = r_tx_bit_q + 3'd1;
                        if (r_tx_bit_q == 3'd7)
                            w_tx_state_d = TX_STOP;
                    end
                    default: w_tx_state_d = TX_IDLE;
                endcase
            end
        end
    end

    // Decoded straight from the state flops so reset forces the line high at once.
    assign bus.Tx      = (r_tx_state_q == TX_START) ? 1'b0 :
                         (r_tx_state_q == TX_DATA)  ? r_tx_shift_q[0] : 1'b1;
    assign bus.Tx_busy = (r_tx_state_q != TX_IDLE);

    // ---------------- receiver ----------------
    rx_state_t        r_rx_state_q, w_rx_state_d;
    logic [1:0]       r_rx_sync_q,  w_rx_sync_d;
    logic [c_RXW-1:0] r_rx_div_q,   w_rx_div_d;
    logic [3:0]       r_rx_tcnt_q,  w_rx_tcnt_d;
    logic [2:0]       r_rx_bit_q,   w_rx_bit_d;
    logic [7:0]       r_rx_shift_q, w_rx_shift_d;
    logic             r_armed_q,    w_armed_d;
    logic             r_ready_q,    w_ready_d;
    logic [7:0]       r_data_q,     w_data_d;
    logic             w_rx_s, w_rx_tick, w_rx_done, w_rx_good;

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            r_rx_state_q <= RX_IDLE;
            r_rx_sync_q  <= 2'b11;
            r_rx_div_q   <= '0;
            r_rx_tcnt_q  <= '0;
            r_rx_bit_q   <= '0;
            r_rx_shift_q <= '0;
            r_armed_q    <= 1'b0;
            r_ready_q    <= 1'b0;
            r_data_q     <= '0;
        end else begin
            r_rx_state_q <= w_rx_state_d;
            r_rx_sync_q  <= w_rx_sync_d;
            r_rx_div_q   <= w_rx_div_d;
            r_rx_tcnt_q  <= w_rx_tcnt_d;
            r_rx_bit_q   <= w_rx_bit_d;
            r_rx_shift_q <= w_rx_shift_d;
            r_armed_q    <= w_armed_d;
            r_ready_q    <= w_ready_d;
            r_data_q     <= w_data_d;
        end
    end

    always_comb begin
        w_rx_sync_d  = {r_rx_sync_q[0], bus.Rx};
        w_rx_s       = r_rx_sync_q[1];
        w_rx_state_d = r_rx_state_q;
        w_rx_div_d   = r_rx_div_q;
        w_rx_tcnt_d  = r_rx_tcnt_q;
        w_rx_bit_d   = r_rx_bit_q;
        w_rx_shift_d = r_rx_shift_q;
        w_rx_done    = 1'b0;
        w_rx_good    = 1'b0;
        w_rx_tick    = (r_rx_div_q == c_RX_LAST);
        if (r_rx_state_q == RX_IDLE) begin
            // Oversample phase restarts on the falling edge of the start bit.
            w_rx_div_d  = '0;
            w_rx_tcnt_d = '0;
            if (r_armed_q && !w_rx_s)
                w_rx_state_d = RX_START;
        end else begin
            w_rx_div_d = w_rx_tick ? '0 : r_rx_div_q + 1'b1;
            if (w_rx_tick) begin
                w_rx_tcnt_d = r_rx_tcnt_q + 4'd1;
                case (r_rx_state_q)
                    RX_START: begin
                        // Half a bit in: confirm the start bit, otherwise it was a glitch.
                        if (r_rx_tcnt_q == 4'd7) begin
                            w_rx_tcnt_d  = '0;
                            w_rx_bit_d   = '0;
                            w_rx_state_d = w_rx_s ? RX_IDLE : RX_DATA;
                        end
                    end
                    RX_DATA: begin
                        if (r_rx_tcnt_q == 4'd15) begin
                            w_rx_shift_d = {w_rx_s, r_rx_shift_q[7:1]};
                            w_rx_bit_d   = r_rx_bit_q + 3'd1;
                            if (r_rx_bit_q == 3'd7)
                                w_rx_state_d = RX_STOP;
                        end
                    end
                    default: begin
                        if (r_rx_tcnt_q == 4'd15) begin
                            w_rx_done    = 1'b1;
                            w_rx_good    = w_rx_s;
                            w_rx_state_d = RX_IDLE;
                        end
                    end
                endcase
            end
        end

        w_armed_d = r_armed_q;
        if (w_rx_done)
            w_armed_d = 1'b0;
        if (bus.Rx_en)
            w_armed_d = 1'b1;

        // Set wins over clear when both land on the same edge.
        w_ready_d = r_ready_q;
        if (bus.ready_clr)
            w_ready_d = 1'b0;
        if (w_rx_good)
            w_ready_d = 1'b1;

        w_data_d = w_rx_good ? r_rx_shift_q : r_data_q;
    end

    assign bus.ready    = r_ready_q;
    assign bus.data_out = r_data_q;
endmodule
`default_nettype wire

// File: tb/tb_uart_top.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_top
//  Description : Self-checking bench for uart_top. A behavioural model tracks
//                expected Tx frame bits, busy length, armed/ready/data_out.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_top;
    localparam int BIT_CLKS   = 434;
    localparam int FRAME_CLKS = 10 * BIT_CLKS;

    logic clk_50m = 1'b0;
    logic rst     = 1'b1;
    always #10 clk_50m = ~clk_50m;

    uart_top_if bus();
    uart_top dut (.clk_50m(clk_50m), .rst(rst), .bus(bus));

    logic loop_en;
    logic rx_drv;
    assign bus.Rx = loop_en ? bus.Tx : rx_drv;

    int         n_vec = 0;
    int         n_err = 0;
    logic       model_ready;
    logic [7:0] model_data;
    logic       model_armed;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_rx_state();
        check_eq("ready", {31'd0, bus.ready}, {31'd0, model_ready});
        check_eq("data_out", {24'd0, bus.data_out}, {24'd0, model_data});
    endtask

    task automatic clear_ready();
        @(negedge clk_50m);
        bus.ready_clr = 1'b1;
        @(negedge clk_50m);
        bus.ready_clr = 1'b0;
        model_ready = 1'b0;
        check_eq("ready_clr", {31'd0, bus.ready}, 32'd0);
    endtask

    task automatic arm_rx();
        @(negedge clk_50m);
        bus.Rx_en = 1'b1;
        @(negedge clk_50m);
        bus.Rx_en = 1'b0;
        model_armed = 1'b1;
    endtask

    // Sends one frame through the transmitter, checking each bit at its centre
    // and the busy length; optionally fires a second request mid-frame.
    task automatic tx_frame(input logic [7:0] b, input bit arm, input bit inject);
        logic [9:0] fr;
        int busy_cnt;
        fr = {1'b1, b, 1'b0};
        busy_cnt = 0;
        @(negedge clk_50m);
        bus.data_in = b;
        bus.Tx_en   = 1'b1;
        bus.Rx_en   = arm;
        if (arm) model_armed = 1'b1;
        @(posedge clk_50m);
        for (int k = 1; k <= FRAME_CLKS; k++) begin
            @(negedge clk_50m);
            if (k == 1) begin
                bus.Tx_en = 1'b0;
                bus.Rx_en = 1'b0;
            end
            if (bus.Tx_busy) busy_cnt++;
            if ((k - 1) % BIT_CLKS == BIT_CLKS / 2 - 1)
                check_eq("tx_bit", {31'd0, bus.Tx}, {31'd0, fr[(k - 1) / BIT_CLKS]});
            if (inject && k == 2000) begin
                bus.data_in = 8'h3C;
                bus.Tx_en   = 1'b1;
            end
            if (inject && k == 2001)
                bus.Tx_en = 1'b0;
        end
        check_eq("tx_busy_len", busy_cnt, FRAME_CLKS);
        @(negedge clk_50m);
        check_eq("tx_busy_end", {31'd0, bus.Tx_busy}, 32'd0);
        check_eq("tx_idle", {31'd0, bus.Tx}, 32'd1);
        if (loop_en && model_armed) begin
            model_ready = 1'b1;
            model_data  = b;
            model_armed = 1'b0;
        end
        check_rx_state();
    endtask

    // Bench-driven serial frame on Rx with a selectable stop bit.
    task automatic rx_frame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_50m);
            rx_drv = fr[i];
            repeat (BIT_CLKS - 1) @(negedge clk_50m);
        end
        @(negedge clk_50m);
        rx_drv = 1'b1;
        repeat (200) @(negedge clk_50m);
        if (model_armed) begin
            if (stop_bit) begin
                model_ready = 1'b1;
                model_data  = b;
            end
            model_armed = 1'b0;
        end
        check_rx_state();
    endtask

    initial begin
        logic [7:0] rb;
        bus.data_in   = 8'h00;
        bus.Tx_en     = 1'b0;
        bus.Rx_en     = 1'b0;
        bus.ready_clr = 1'b0;
        loop_en       = 1'b1;
        rx_drv        = 1'b1;
        model_ready   = 1'b0;
        model_data    = 8'h00;
        model_armed   = 1'b0;

        repeat (3) @(negedge clk_50m);
        check_eq("rst_tx", {31'd0, bus.Tx}, 32'd1);
        check_eq("rst_busy", {31'd0, bus.Tx_busy}, 32'd0);
        check_rx_state();
        rst = 1'b0;

        // Loopback: fixed bytes then random bytes
        for (int i = 0; i < 6; i++) begin
            rb = (i < 3) ? 8'(i) : 8'($urandom_range(0, 255));
            tx_frame(rb, 1'b1, 1'b0);
            clear_ready();
        end

        // A5 with an ignored mid-frame request for 3C
        tx_frame(8'hA5, 1'b1, 1'b1);
        repeat (10) @(negedge clk_50m);
        check_eq("no_queue_busy", {31'd0, bus.Tx_busy}, 32'd0);
        check_eq("no_queue_data", {24'd0, bus.data_out}, 32'hA5);
        clear_ready();

        // Bench-driven Rx: framing error, then unarmed, then armed frames
        loop_en = 1'b0;
        arm_rx();
        rx_frame(8'h55, 1'b0);
        rx_frame(8'($urandom_range(0, 255)), 1'b1);
        arm_rx();
        rx_frame(8'($urandom_range(0, 255)), 1'b1);
        arm_rx();
        rx_frame(8'($urandom_range(0, 255)), 1'b1);

        // Reset in the middle of the data bits of a TX frame
        loop_en = 1'b1;
        @(negedge clk_50m);
        bus.data_in = 8'h00;
        bus.Tx_en   = 1'b1;
        bus.Rx_en   = 1'b1;
        @(negedge clk_50m);
        bus.Tx_en   = 1'b0;
        bus.Rx_en   = 1'b0;
        repeat (BIT_CLKS * 4) @(negedge clk_50m);
        check_eq("pre_rst_tx", {31'd0, bus.Tx}, 32'd0);
        rst = 1'b1;
        #1;
        model_ready = 1'b0;
        model_data  = 8'h00;
        model_armed = 1'b0;
        check_eq("mid_rst_tx", {31'd0, bus.Tx}, 32'd1);
        check_eq("mid_rst_busy", {31'd0, bus.Tx_busy}, 32'd0);
        check_rx_state();
        @(negedge clk_50m);
        @(negedge clk_50m);
        rst = 1'b0;
        tx_frame(8'($urandom_range(0, 255)), 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
